// File: rtl/program_loader_pkg.sv
// Shared sizes, loader state encoding and small helpers for the byte-stream program loader.
package program_loader_pkg;

    localparam int ADDR_WIDTH  = 4;
    localparam int DATA_WIDTH  = 8;
    localparam int RAM_DEPTH   = 16;
    localparam int COUNT_WIDTH = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LEN,
        LD_DATA,
        LD_CSUM,
        LD_DONE,
        LD_ERROR
    } loader_state_t;

    function automatic logic is_receiving(input loader_state_t s);
        return (s == LD_LEN) || (s == LD_DATA) || (s == LD_CSUM);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] csum_add(input logic [DATA_WIDTH-1:0] acc,
                                                       input logic [DATA_WIDTH-1:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/program_loader.sv
// Framed byte-stream loader (LEN, data bytes, CSUM) writing RAM from address 0
// and holding the CPU halted while a frame is in flight or after a bad frame.
module program_loader #(
    parameter int ADDR_WIDTH = program_loader_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = program_loader_pkg::DATA_WIDTH,
    parameter int RAM_DEPTH  = program_loader_pkg::RAM_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  cpu_halt,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    import program_loader_pkg::*;

    // One extra bit so a full-depth frame reaches RAM_DEPTH without wrapping.
    localparam int CW = ADDR_WIDTH + 1;

    loader_state_t state_q, state_next;

    logic [CW-1:0]         count_q;
    logic [CW-1:0]         len_q;
    logic [DATA_WIDTH-1:0] csum_q;
    logic                  in_ready_q;
    logic                  ram_we_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [DATA_WIDTH-1:0] ram_wdata_q;
    logic                  cpu_halt_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;

    logic xfer;
    logic len_bad;
    logic last_byte;
    logic start_ok;

    assign xfer      = in_valid && in_ready_q;
    assign len_bad   = (in_data == '0) || (in_data > DATA_WIDTH'(RAM_DEPTH));
    assign last_byte = (CW'(count_q + 1'b1) == len_q);
    assign start_ok  = start && ((state_q == LD_IDLE) || (state_q == LD_DONE) ||
                                 (state_q == LD_ERROR));

    always_comb begin
        state_next = state_q;
        case (state_q)
            LD_IDLE, LD_DONE, LD_ERROR: begin
                if (start) state_next = LD_LEN;
            end
            LD_LEN: begin
                if (xfer) state_next = len_bad ? LD_ERROR : LD_DATA;
            end
            LD_DATA: begin
                if (xfer && last_byte) state_next = LD_CSUM;
            end
            LD_CSUM: begin
                if (xfer) state_next = (in_data == csum_q) ? LD_DONE : LD_ERROR;
            end
            default: state_next = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LD_IDLE;
            count_q     <= '0;
            len_q       <= '0;
            csum_q      <= '0;
            in_ready_q  <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_halt_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q    <= state_next;
            // Status flags are decoded from the next state so they line up with state_q.
            in_ready_q <= is_receiving(state_next);
            busy_q     <= is_receiving(state_next);
            cpu_halt_q <= is_receiving(state_next) || (state_next == LD_ERROR);
            done_q     <= (state_next == LD_DONE);
            error_q    <= (state_next == LD_ERROR);
            ram_we_q   <= 1'b0;

            if (start_ok) begin
                count_q <= '0;
                csum_q  <= '0;
            end

            if ((state_q == LD_LEN) && xfer) begin
                len_q <= in_data[CW-1:0];
            end

            if ((state_q == LD_DATA) && xfer) begin
                ram_we_q    <= 1'b1;
                ram_addr_q  <= count_q[ADDR_WIDTH-1:0];
                ram_wdata_q <= in_data;
                csum_q      <= csum_add(csum_q, in_data);
                count_q     <= count_q + 1'b1;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign cpu_halt  = cpu_halt_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: RAM writes are scoreboarded against
// expectations queued when each data byte is handed over.
module tb_program_loader;

    logic       clk;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       cpu_halt;
    logic       busy;
    logic       done;
    logic       error;

    int assertions = 0;
    int failures   = 0;
    int cycle      = 0;
    int we_count   = 0;

    logic [11:0] exp_q[$];
    int          we_cycles[$];
    logic [7:0]  model_ram[16];

    program_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .cpu_halt  (cpu_halt),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM-side monitor: every write must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [11:0] e;
        cycle++;
        if (!reset && ram_we) begin
            we_count++;
            we_cycles.push_back(cycle);
            assertions++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL ram_write_unexpected: got addr=%0h data=%0h, required no write",
                         ram_addr, ram_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({ram_addr, ram_wdata} !== e) begin
                    failures++;
                    $display("FAIL ram_write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                             ram_addr, ram_wdata, e[11:8], e[7:0]);
                end
            end
            model_ram[ram_addr] = ram_wdata;
        end
    end

    // Called and returns at a negedge; in_valid is left as last driven.
    task automatic send_byte(input logic [7:0] b, input bit is_data, input int addr, input bit rnd);
        int  n    = 0;
        bit  sent = 0;
        while (!sent) begin
            in_data  = b;
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (in_valid && in_ready) begin
                sent = 1;
                if (is_data) exp_q.push_back({4'(addr), b});
            end
            @(negedge clk);
            n++;
            if (!sent && n > 60) begin
                assertions++;
                failures++;
                $display("FAIL handshake_timeout: got in_ready=%0b for %0d cycles, required 1", in_ready, n);
                break;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] bytes[$], input bit rnd);
        for (int i = 0; i < bytes.size(); i++) begin
            send_byte(bytes[i], (i > 0) && (i < bytes.size() - 1), i - 1, rnd);
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        assertions++;
        if ({in_ready, ram_we, ram_addr, ram_wdata, cpu_halt, busy, done, error} !== 18'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %05h, required 00000",
                     {in_ready, ram_we, ram_addr, ram_wdata, cpu_halt, busy, done, error});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        assertions++;
        if ({in_ready, busy, cpu_halt} !== 3'b000) begin
            failures++;
            $display("FAIL idle_after_reset: got ready/busy/halt=%03b, required 000", {in_ready, busy, cpu_halt});
        end
    endtask

    task automatic test_good_frame();
        int base = we_count;
        pulse_start();
        assertions++;
        if ({in_ready, busy, cpu_halt} !== 3'b111) begin
            failures++;
            $display("FAIL len_state_flags: got ready/busy/halt=%03b, required 111", {in_ready, busy, cpu_halt});
        end
        send_frame('{8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h31}, 0);
        repeat (3) @(negedge clk);
        assertions++;
        if ({done, error, cpu_halt, busy} !== 4'b1000) begin
            failures++;
            $display("FAIL good_frame_status: got done/err/halt/busy=%04b, required 1000",
                     {done, error, cpu_halt, busy});
        end
        assertions++;
        if (we_count - base != 3) begin
            failures++;
            $display("FAIL good_frame_we_count: got %0d, required 3", we_count - base);
        end
        assertions++;
        if ({model_ram[0], model_ram[1], model_ram[2]} !== 24'hAABBCC) begin
            failures++;
            $display("FAIL good_frame_ram: got %02h %02h %02h, required AA BB CC",
                     model_ram[0], model_ram[1], model_ram[2]);
        end
    endtask

    task automatic test_bad_csum();
        int base = we_count;
        pulse_start();
        send_frame('{8'h02, 8'h11, 8'h22, 8'h00}, 0);
        repeat (3) @(negedge clk);
        assertions++;
        if ({done, error, cpu_halt, busy} !== 4'b0110) begin
            failures++;
            $display("FAIL bad_csum_status: got done/err/halt/busy=%04b, required 0110",
                     {done, error, cpu_halt, busy});
        end
        assertions++;
        if ((we_count - base != 2) || ({model_ram[0], model_ram[1], model_ram[2]} !== 24'h1122CC)) begin
            failures++;
            $display("FAIL bad_csum_ram: got writes=%0d ram=%02h %02h %02h, required 2 11 22 CC",
                     we_count - base, model_ram[0], model_ram[1], model_ram[2]);
        end
    endtask

    task automatic test_bad_len();
        logic [7:0] lens[2] = '{8'h00, 8'h11};
        foreach (lens[k]) begin
            int base = we_count;
            pulse_start();
            assertions++;
            if (done !== 1'b0 || error !== 1'b0) begin
                failures++;
                $display("FAIL start_clears_flags: got done=%0b err=%0b, required 0 0", done, error);
            end
            send_frame('{lens[k]}, 0);
            repeat (3) @(negedge clk);
            assertions++;
            if ({done, error, cpu_halt, in_ready} !== 4'b0110 || we_count != base) begin
                failures++;
                $display("FAIL bad_len_%02h: got done/err/halt/ready=%04b writes=%0d, required 0110 0",
                         lens[k], {done, error, cpu_halt, in_ready}, we_count - base);
            end
        end
    endtask

    task automatic test_back_to_back();
        int first = we_cycles.size();
        bit consecutive = 1;
        logic [7:0] fr[$];
        fr.push_back(8'h10);
        for (int i = 0; i < 16; i++) fr.push_back(8'(i));
        fr.push_back(8'h78);
        pulse_start();
        send_frame(fr, 0);
        repeat (3) @(negedge clk);
        for (int i = first + 1; i < we_cycles.size(); i++)
            if (we_cycles[i] - we_cycles[i-1] != 1) consecutive = 0;
        assertions++;
        if (we_cycles.size() - first != 16 || !consecutive) begin
            failures++;
            $display("FAIL back_to_back_writes: got %0d writes consecutive=%0b, required 16 1",
                     we_cycles.size() - first, consecutive);
        end
        assertions++;
        if ({done, error, cpu_halt} !== 3'b100 || model_ram[15] !== 8'h0F || model_ram[0] !== 8'h00) begin
            failures++;
            $display("FAIL full_depth_frame: got done/err/halt=%03b ram0=%02h ram15=%02h, required 100 00 0F",
                     {done, error, cpu_halt}, model_ram[0], model_ram[15]);
        end
    endtask

    task automatic test_random_valid();
        int base = we_count;
        pulse_start();
        send_frame('{8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h31}, 1);
        repeat (3) @(negedge clk);
        assertions++;
        if ({done, error} !== 2'b10 || we_count - base != 3) begin
            failures++;
            $display("FAIL random_valid_status: got done/err=%02b writes=%0d, required 10 3",
                     {done, error}, we_count - base);
        end
        assertions++;
        if ({model_ram[0], model_ram[1], model_ram[2], model_ram[3]} !== 32'hAABBCC03) begin
            failures++;
            $display("FAIL random_valid_ram: got %02h %02h %02h %02h, required AA BB CC 03",
                     model_ram[0], model_ram[1], model_ram[2], model_ram[3]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        pulse_start();
        send_byte(8'h03, 0, 0, 0);
        send_byte(8'hAA, 1, 0, 0);
        send_byte(8'hBB, 1, 1, 0);
        #2 reset = 1'b1;
        in_valid = 1'b0;
        #1;
        assertions++;
        if ({in_ready, ram_we, ram_addr, ram_wdata, cpu_halt, busy, done, error} !== 18'h0) begin
            failures++;
            $display("FAIL reset_mid_frame: got %05h, required 00000",
                     {in_ready, ram_we, ram_addr, ram_wdata, cpu_halt, busy, done, error});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        base = we_count;
        pulse_start();
        send_byte(8'h03, 0, 0, 0);
        send_byte(8'hAA, 1, 0, 0);
        start = 1'b1;
        send_byte(8'hBB, 1, 1, 0);
        start = 1'b0;
        send_byte(8'hCC, 1, 2, 0);
        send_byte(8'h31, 0, 0, 0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        assertions++;
        if ({done, error, cpu_halt} !== 3'b100 || we_count - base != 3 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL after_reset_frame: got done/err/halt=%03b writes=%0d pending=%0d, required 100 3 0",
                     {done, error, cpu_halt}, we_count - base, exp_q.size());
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        foreach (model_ram[i]) model_ram[i] = 8'h00;
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_bad_len();
        test_back_to_back();
        test_random_valid();
        test_reset_mid_frame();
        assertions++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_writes: got %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
